sd_block_reader: RTL

- Downstream neighbour of the SD SPI initialisation stage.
- Once the card is initialised, it issues CMD17 (READ_SINGLE_BLOCK) over SPI and collects the R1 response and the start token.
- It streams the 512-byte data block out one byte at a time with a valid strobe, then releases the bus.
- Feeds the display/debug and frame-buffer logic.

---
 rtl/sd_pkg.sv | 43 ++++
 rtl/sd_spi_byte.sv | 76 +++++++
 rtl/sd_block_reader.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_pkg.sv
// Shared constants, error codes and FSM encoding for the SD SPI block-read path.
// Also holds the CMD17 frame byte selector used by the reader.
package sd_pkg;

    localparam logic [7:0] CMD17       = 8'h51;
    localparam logic [7:0] TOKEN_START = 8'hFE;
    localparam logic [7:0] DUMMY       = 8'hFF;

    typedef enum logic [2:0] {
        ERR_NONE          = 3'd0,
        ERR_R1_TIMEOUT    = 3'd1,
        ERR_R1_BAD        = 3'd2,
        ERR_TOKEN_TIMEOUT = 3'd3,
        ERR_DATA          = 3'd4
    } err_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CMD   = 4'd1,
        ST_R1    = 4'd2,
        ST_TOKEN = 4'd3,
        ST_DATA  = 4'd4,
        ST_CRC   = 4'd5,
        ST_TRAIL = 4'd6,
        ST_FIN   = 4'd7,
        ST_FAIL  = 4'd8
    } state_e;

    // Byte idx of the 6-byte CMD17 frame; the last byte is a dummy CRC.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] addr);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD17;
            3'd1:    b = addr[31:24];
            3'd2:    b = addr[23:16];
            3'd3:    b = addr[15:8];
            3'd4:    b = addr[7:0];
            default: b = DUMMY;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sd_spi_byte.sv
// Full-duplex SPI mode-0 byte shifter with a CLK_DIV clock divider.
// ready is also high in the final clk of a byte so the next go keeps SCLK periodic.
module sd_spi_byte #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] tx,
    output logic [7:0] rx,
    output logic       ready,
    output logic       SCLK,
    output logic       DI,
    input  logic       DO
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_r;
    logic [3:0]    phase_r;
    logic          active_r;
    logic [7:0]    sh_r;
    logic [7:0]    rx_r;
    logic          sclk_r;
    logic          di_r;
    logic          half_end_s;
    logic          last_s;

    assign half_end_s = active_r && (div_r == DIV_LAST);
    assign last_s     = half_end_s && (phase_r == 4'd15);
    assign ready      = !active_r || last_s;
    assign rx         = rx_r;
    assign SCLK       = sclk_r;
    assign DI         = di_r;

    // Even half-periods are SCLK low, odd ones high; sample on rise, shift on fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r    <= '0;
            phase_r  <= 4'd0;
            active_r <= 1'b0;
            sh_r     <= 8'hFF;
            rx_r     <= 8'h00;
            sclk_r   <= 1'b0;
            di_r     <= 1'b1;
        end else if (go && ready) begin
            active_r <= 1'b1;
            div_r    <= '0;
            phase_r  <= 4'd0;
            sh_r     <= tx;
            di_r     <= tx[7];
            sclk_r   <= 1'b0;
        end else if (half_end_s) begin
            div_r   <= '0;
            phase_r <= phase_r + 4'd1;
            if (!phase_r[0]) begin
                sclk_r <= 1'b1;
                rx_r   <= {rx_r[6:0], DO};
            end else begin
                sclk_r <= 1'b0;
                if (phase_r == 4'd15) begin
                    active_r <= 1'b0;
                    di_r     <= 1'b1;
                end else begin
                    sh_r <= {sh_r[6:0], 1'b1};
                    di_r <= sh_r[6];
                end
            end
        end else if (active_r) begin
            div_r <= div_r + DW'(1);
        end else begin
            di_r <= 1'b1;
        end
    end

endmodule

// File: rtl/sd_block_reader.sv
// CMD17 single-block reader: sends the command, polls R1 and the start token,
// streams BLOCK_LEN bytes with a valid strobe, then releases the card.
module sd_block_reader #(
    parameter int CLK_DIV     = 4,
    parameter int R1_TRIES    = 8,
    parameter int TOKEN_TRIES = 4096,
    parameter int BLOCK_LEN   = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        DO,
    output logic        SCLK,
    output logic        DI,
    output logic        CS,
    output logic [7:0]  data,
    output logic        data_valid,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code
);
    import sd_pkg::*;

    localparam logic [15:0] R1_LAST  = 16'(R1_TRIES - 1);
    localparam logic [15:0] TOK_LAST = 16'(TOKEN_TRIES - 1);
    localparam logic [15:0] BLK_LAST = 16'(BLOCK_LEN - 1);

    state_e      state_r, state_n;
    logic [15:0] cnt_r, cnt_n;
    logic [31:0] addr_r, addr_n;
    logic        cs_r, cs_n, busy_r, busy_n, done_r, done_n, error_r, error_n;
    logic        dv_r, dv_n;
    logic [2:0]  err_r, err_n;
    logic [7:0]  data_r, data_n;
    logic        go_s, ready_s;
    logic [7:0]  tx_s, rx_s;

    sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_spi (
        .clk(clk), .reset(reset), .go(go_s), .tx(tx_s), .rx(rx_s),
        .ready(ready_s), .SCLK(SCLK), .DI(DI), .DO(DO)
    );

    // Next-state logic; every decision is taken on a byte boundary (ready_s).
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        addr_n  = addr_r;
        cs_n    = cs_r;
        busy_n  = busy_r;
        done_n  = 1'b0;
        error_n = 1'b0;
        err_n   = err_r;
        data_n  = data_r;
        dv_n    = 1'b0;
        go_s    = 1'b0;
        tx_s    = DUMMY;
        case (state_r)
            ST_IDLE: begin
                cs_n  = 1'b1;
                cnt_n = 16'd0;
                if (start) begin
                    addr_n  = addr;
                    err_n   = ERR_NONE;
                    busy_n  = 1'b1;
                    cs_n    = 1'b0;
                    go_s    = 1'b1;
                    tx_s    = CMD17;
                    state_n = ST_CMD;
                end else begin
                    busy_n = 1'b0;
                end
            end
            ST_CMD: begin
                if (ready_s) begin
                    go_s = 1'b1;
                    if (cnt_r == 16'd5) begin
                        cnt_n   = 16'd0;
                        state_n = ST_R1;
                    end else begin
                        cnt_n = cnt_r + 16'd1;
                        tx_s  = cmd_byte(cnt_r[2:0] + 3'd1, addr_r);
                    end
                end else begin
                    go_s = 1'b0;
                end
            end
            ST_R1: begin
                if (ready_s) begin
                    go_s = 1'b1;
                    if (!rx_s[7]) begin
                        cnt_n = 16'd0;
                        if (rx_s == 8'h00) begin
                            state_n = ST_TOKEN;
                        end else begin
                            state_n = ST_FAIL;
                            err_n   = ERR_R1_BAD;
                            cs_n    = 1'b1;
                        end
                    end else if (cnt_r == R1_LAST) begin
                        cnt_n   = 16'd0;
                        state_n = ST_FAIL;
                        err_n   = ERR_R1_TIMEOUT;
                        cs_n    = 1'b1;
                    end else begin
                        cnt_n = cnt_r + 16'd1;
                    end
                end else begin
                    go_s = 1'b0;
                end
            end
            ST_TOKEN: begin
                if (ready_s) begin
                    go_s = 1'b1;
                    if (rx_s == TOKEN_START) begin
                        cnt_n   = 16'd0;
                        state_n = ST_DATA;
                    end else if (rx_s[7:4] == 4'h0) begin
                        cnt_n   = 16'd0;
                        state_n = ST_FAIL;
                        err_n   = ERR_DATA;
                        cs_n    = 1'b1;
                    end else if (cnt_r == TOK_LAST) begin
                        cnt_n   = 16'd0;
                        state_n = ST_FAIL;
                        err_n   = ERR_TOKEN_TIMEOUT;
                        cs_n    = 1'b1;
                    end else begin
                        cnt_n = cnt_r + 16'd1;
                    end
                end else begin
                    go_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (ready_s) begin
                    go_s   = 1'b1;
                    data_n = rx_s;
                    dv_n   = 1'b1;
                    if (cnt_r == BLK_LAST) begin
                        cnt_n   = 16'd0;
                        state_n = ST_CRC;
                    end else begin
                        cnt_n = cnt_r + 16'd1;
                    end
                end else begin
                    go_s = 1'b0;
                end
            end
            ST_CRC: begin
                if (ready_s) begin
                    go_s = 1'b1;
                    if (cnt_r == 16'd1) begin
                        cnt_n   = 16'd0;
                        cs_n    = 1'b1;
                        state_n = ST_TRAIL;
                    end else begin
                        cnt_n = cnt_r + 16'd1;
                    end
                end else begin
                    go_s = 1'b0;
                end
            end
            ST_TRAIL: begin
                if (ready_s) begin
                    state_n = ST_FIN;
                end else begin
                    state_n = ST_TRAIL;
                end
            end
            ST_FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
            ST_FAIL: begin
                if (ready_s) begin
                    error_n = 1'b1;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_FAIL;
                end
            end
            default: begin
                cs_n    = 1'b1;
                busy_n  = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer without a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            addr_r  <= 32'd0;
            cs_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
            err_r   <= 3'd0;
            data_r  <= 8'h00;
            dv_r    <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            addr_r  <= addr_n;
            cs_r    <= cs_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            error_r <= error_n;
            err_r   <= err_n;
            data_r  <= data_n;
            dv_r    <= dv_n;
        end
    end

    assign CS         = cs_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign error      = error_r;
    assign err_code   = err_r;
    assign data       = data_r;
    assign data_valid = dv_r;

endmodule
